// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-entry path: key codes,
// entry-sequencer state encoding and the default operand magnitude limit.
package calc_pkg;

  // Largest operand magnitude accepted by default; operands are 7-bit magnitudes.
  localparam int MAX_MAG_DEFAULT = 127;

  // Non-digit key codes. Codes 0-9 are digits; E and F are unused.
  localparam logic [3:0] KEY_SIGN = 4'hA;
  localparam logic [3:0] KEY_PLUS = 4'hB;
  localparam logic [3:0] KEY_EQ   = 4'hC;
  localparam logic [3:0] KEY_CLR  = 4'hD;

  // Entry sequencer states; the encoding is exported for the display mux.
  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } calc_state_t;

  // True for the decimal digit keys 0-9.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator: appends one digit to a magnitude and rejects the
// result if it would exceed MAX_MAG. Purely combinational; shared by A and B.
module dec_accum
  import calc_pkg::*;
#(
  parameter int MAX_MAG = MAX_MAG_DEFAULT
) (
  input  logic [6:0] mag,
  input  logic [3:0] digit,
  output logic [6:0] next_mag,
  output logic       reject
);

  // 11 bits holds the worst case 127*10 + 9 = 1279 without wrapping.
  logic [10:0] cand;

  // Form mag*10 + digit and keep the old magnitude when it is out of range.
  always_comb begin
    cand     = (11'(mag) * 11'd10) + 11'(digit);
    reject   = (cand > 11'(MAX_MAG));
    next_mag = reject ? mag : cand[6:0];
  end

endmodule

// File: rtl/calc_operand_entry.sv
// Keypad operand-entry sequencer. Accumulates decimal keys into two
// sign-magnitude operands and presents them, frozen and flagged valid, to the
// signed adder once '=' is pressed.
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int MAX_MAG = MAX_MAG_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Key_Valid,
  input  logic [3:0] Key_Code,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       Sign_A,
  output logic       Sign_B,
  output logic       Op_Valid,
  output logic       Entry_Err,
  output logic [1:0] State
);

  calc_state_t state_reg;
  logic [6:0]  a_reg;
  logic [6:0]  b_reg;
  logic        sign_a_reg;
  logic        sign_b_reg;
  logic        op_valid_reg;
  logic        entry_err_reg;

  logic [6:0]  cur_mag;
  logic [6:0]  acc_next;
  logic        acc_reject;

  // Only the operand currently being entered feeds the shared accumulator.
  always_comb begin
    cur_mag = (state_reg == ST_ENTER_B) ? b_reg : a_reg;
  end

  dec_accum #(
    .MAX_MAG (MAX_MAG)
  ) u_dec_accum (
    .mag      (cur_mag),
    .digit    (Key_Code),
    .next_mag (acc_next),
    .reject   (acc_reject)
  );

  // Entry FSM with the operand, sign, valid and error registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg     <= ST_ENTER_A;
      a_reg         <= '0;
      b_reg         <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      op_valid_reg  <= 1'b0;
      entry_err_reg <= 1'b0;
    end else if (state_reg == ST_ILLEGAL ||
                 (Key_Valid && Key_Code == KEY_CLR)) begin
      // Illegal-state recovery and the clear key both behave like reset.
      state_reg     <= ST_ENTER_A;
      a_reg         <= '0;
      b_reg         <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      op_valid_reg  <= 1'b0;
      entry_err_reg <= 1'b0;
    end else if (Key_Valid) begin
      case (state_reg)
        ST_ENTER_A: begin
          if (is_digit(Key_Code)) begin
            if (acc_reject) entry_err_reg <= 1'b1;
            else            a_reg         <= acc_next;
          end else if (Key_Code == KEY_SIGN) begin
            sign_a_reg <= ~sign_a_reg;
          end else if (Key_Code == KEY_PLUS) begin
            // B and its sign are already zero here, so no clearing is needed.
            state_reg <= ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (is_digit(Key_Code)) begin
            if (acc_reject) entry_err_reg <= 1'b1;
            else            b_reg         <= acc_next;
          end else if (Key_Code == KEY_SIGN) begin
            sign_b_reg <= ~sign_b_reg;
          end else if (Key_Code == KEY_EQ) begin
            state_reg    <= ST_DONE;
            op_valid_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          // Only a digit leaves DONE; it seeds A and starts a fresh calculation.
          if (is_digit(Key_Code)) begin
            state_reg     <= ST_ENTER_A;
            a_reg         <= {3'b000, Key_Code};
            sign_a_reg    <= 1'b0;
            b_reg         <= '0;
            sign_b_reg    <= 1'b0;
            op_valid_reg  <= 1'b0;
            entry_err_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_ENTER_A;
        end
      endcase
    end
  end

  // Outputs come straight from registers; bit 7 of each magnitude is always 0.
  always_comb begin
    A         = {1'b0, a_reg};
    B         = {1'b0, b_reg};
    Sign_A    = sign_a_reg;
    Sign_B    = sign_b_reg;
    Op_Valid  = op_valid_reg;
    Entry_Err = entry_err_reg;
    State     = state_reg;
  end

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed-vector bench for calc_operand_entry: keys are driven on the falling
// edge, captured on the rising edge and outputs checked on the next falling edge.
module tb_calc_operand_entry;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Key_Valid = 1'b0;
  logic [3:0] Key_Code = 4'h7;
  logic [7:0] A;
  logic [7:0] B;
  logic       Sign_A;
  logic       Sign_B;
  logic       Op_Valid;
  logic       Entry_Err;
  logic [1:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  calc_operand_entry #(
    .MAX_MAG (127)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Key_Valid (Key_Valid),
    .Key_Code  (Key_Code),
    .A         (A),
    .B         (B),
    .Sign_A    (Sign_A),
    .Sign_B    (Sign_B),
    .Op_Valid  (Op_Valid),
    .Entry_Err (Entry_Err),
    .State     (State)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic expect_all(input string tag, input int a, input int sa,
                            input int b, input int sb, input int ov,
                            input int err, input int st);
    check({tag, ".A"},         int'(A),         a);
    check({tag, ".Sign_A"},    int'(Sign_A),    sa);
    check({tag, ".B"},         int'(B),         b);
    check({tag, ".Sign_B"},    int'(Sign_B),    sb);
    check({tag, ".Op_Valid"},  int'(Op_Valid),  ov);
    check({tag, ".Entry_Err"}, int'(Entry_Err), err);
    check({tag, ".State"},     int'(State),     st);
  endtask

  // One single-cycle strobe; returns on the following falling edge.
  task automatic press(input logic [3:0] code);
    Key_Code  = code;
    Key_Valid = 1'b1;
    @(negedge Clk);
    Key_Valid = 1'b0;
    Key_Code  = 4'h7;
  endtask

  task automatic press_seq(input logic [3:0] codes[$]);
    foreach (codes[i]) press(codes[i]);
  endtask

  initial begin
    // Reset held low across a few edges.
    repeat (3) @(negedge Clk);
    expect_all("reset", 0, 0, 0, 0, 0, 0, 0);
    Rst = 1'b1;

    // First key after reset release is honoured immediately.
    press(4'd1);
    check("first_key.A", int'(A), 1);
    press(4'd2);
    press(4'hB);
    press_seq('{4'd3, 4'd4});
    expect_all("enter_b", 12, 0, 34, 0, 0, 0, 1);
    press(4'hC);
    expect_all("eq", 12, 0, 34, 0, 1, 0, 2);

    // Sign, plus, equals and E/F are ignored in DONE; idle cycles too.
    press_seq('{4'hA, 4'hB, 4'hC, 4'hE, 4'hF});
    repeat (2) @(negedge Clk);
    expect_all("done_hold", 12, 0, 34, 0, 1, 0, 2);

    // A digit in DONE starts a new calculation.
    press(4'd9);
    expect_all("new_calc", 9, 0, 0, 0, 0, 0, 0);

    // Clear, then signed entry with a double toggle on B.
    press(4'hD);
    expect_all("clear1", 0, 0, 0, 0, 0, 0, 0);
    press_seq('{4'd5, 4'hA, 4'hB, 4'd7, 4'hA, 4'hA, 4'hC});
    expect_all("signs", 5, 1, 7, 0, 1, 0, 2);

    // Equals ignored in ENTER_A; E/F ignored; sign toggles on zero magnitude.
    press(4'hD);
    press_seq('{4'hC, 4'hE, 4'hF});
    expect_all("ignore_a", 0, 0, 0, 0, 0, 0, 0);
    press(4'hA);
    expect_all("neg_zero", 0, 1, 0, 0, 0, 0, 0);
    press(4'hA);

    // Exactly MAX_MAG is accepted, one more digit is rejected.
    press_seq('{4'd1, 4'd2, 4'd7});
    expect_all("max_ok", 127, 0, 0, 0, 0, 0, 0);
    press(4'd1);
    expect_all("max_rej", 127, 0, 0, 0, 0, 1, 0);
    press(4'hD);
    expect_all("clear2", 0, 0, 0, 0, 0, 0, 0);

    // 130 is rejected; error stays sticky through plus and equals.
    press_seq('{4'd1, 4'd3, 4'd0});
    expect_all("rej130", 13, 0, 0, 0, 0, 1, 0);
    press(4'hB);
    press(4'hB);
    press_seq('{4'd9, 4'd9, 4'd9});
    expect_all("b_rej", 13, 0, 99, 0, 0, 1, 1);
    press(4'hA);
    press(4'hC);
    expect_all("err_sticky", 13, 0, 99, 1, 1, 1, 2);
    press(4'd4);
    expect_all("err_cleared", 4, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a low clock phase during ENTER_B.
    press(4'hD);
    press_seq('{4'd1, 4'hB, 4'd3});
    expect_all("pre_async", 1, 0, 3, 0, 0, 0, 1);
    #2;
    Rst = 1'b0;
    #1;
    expect_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    Rst = 1'b1;
    press(4'd6);
    expect_all("after_rst", 6, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
